// File: rtl/fetch_hazard_ctrl.sv
// Front-end pipeline control: load-use detection, mult/div freeze and jump/branch redirect arbitration.
// Optional performance counters are built only when FETCH_CTRL_PERF_EN is defined.
module fetch_hazard_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        md_start,
    input  logic        jump_req,
    input  logic        branch_req,
    output logic        stall,
    output logic        bubble,
    output logic        flush_if,
    output logic        jump_taken,
    output logic        branch_taken,
    output logic        md_busy,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
);

    localparam int CNT_W = $clog2(MD_LATENCY);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [CNT_W-1:0] md_cnt_r;
    logic [CNT_W-1:0] md_cnt_nxt_s;
    logic             lu_s;
    logic             busy_s;
    logic             stall_s;
    logic             redir_s;

    // Load-use hazard between the EX load and the ID source operands
    always_comb begin
        lu_s = ex_mem_read & (ex_rt != 5'd0)
             & ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
    end

    // Next-state and mult/div countdown
    always_comb begin
        state_nxt_s  = state_r;
        md_cnt_nxt_s = md_cnt_r;
        case (state_r)
            RUN: begin
                if (md_start) begin
                    state_nxt_s  = MD_BUSY;
                    md_cnt_nxt_s = MD_LOAD;
                end else begin
                    state_nxt_s  = RUN;
                end
            end
            MD_BUSY: begin
                if (md_cnt_r == CNT_ZERO) begin
                    state_nxt_s = RUN;
                end else begin
                    md_cnt_nxt_s = md_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s  = RUN;
                md_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            md_cnt_r <= CNT_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

    // Stall and redirect decode; reset forces every control low
    always_comb begin
        if (rst) begin
            busy_s  = 1'b0;
            stall_s = 1'b0;
            redir_s = 1'b0;
        end else begin
            busy_s  = (state_r == MD_BUSY);
            stall_s = busy_s | lu_s;
            redir_s = (jump_req | branch_req) & ~stall_s;
        end
    end

    assign stall        = stall_s;
    assign bubble       = stall_s;
    assign md_busy      = busy_s;
    assign flush_if     = redir_s;
    assign jump_taken   = redir_s & jump_req;
    assign branch_taken = redir_s & ~jump_req;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            perf_stall_r <= perf_stall_r + {31'd0, stall_s};
            perf_flush_r <= perf_flush_r + {31'd0, redir_s};
        end
    end

    assign perf_stall_cycles = rst ? 32'd0 : perf_stall_r;
    assign perf_flushes      = rst ? 32'd0 : perf_flush_r;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flushes      = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_fetch_hazard_ctrl;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, md_start, jump_req, branch_req;
    logic        stall, bubble, flush_if, jump_taken, branch_taken, md_busy;
    logic [31:0] perf_stall_cycles, perf_flushes;

    int total = 0;
    int bad   = 0;
    int busy_left = 0;
    int cnt_stall = 0;
    int cnt_flush = 0;

    fetch_hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .md_start(md_start),
        .jump_req(jump_req), .branch_req(branch_req),
        .stall(stall), .bubble(bubble), .flush_if(flush_if),
        .jump_taken(jump_taken), .branch_taken(branch_taken), .md_busy(md_busy),
        .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        md_start = 1'b0; jump_req = 1'b0; branch_req = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied; checks, then advances one cycle.
    // e_* = -1 means no extra directed expectation for that output.
    task automatic cyc(input string tag, input int e_stall, input int e_jt, input int e_bt, input int e_fl);
        bit lu_m, busy_m, stall_m, jt_m, bt_m, fl_m;
        logic [31:0] ps_m, pf_m;
        #2;
        lu_m = ex_mem_read && (ex_rt != 5'd0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        busy_m  = !rst && (busy_left > 0);
        stall_m = !rst && (busy_m || lu_m);
        jt_m    = !rst && !stall_m && jump_req;
        bt_m    = !rst && !stall_m && branch_req && !jump_req;
        fl_m    = !rst && !stall_m && (jump_req || branch_req);
`ifdef FETCH_CTRL_PERF_EN
        ps_m = rst ? 32'd0 : 32'(cnt_stall);
        pf_m = rst ? 32'd0 : 32'(cnt_flush);
`else
        ps_m = 32'd0;
        pf_m = 32'd0;
`endif
        chk({tag, ".stall"},  {31'd0, stall},        {31'd0, stall_m});
        chk({tag, ".bubble"}, {31'd0, bubble},       {31'd0, stall_m});
        chk({tag, ".busy"},   {31'd0, md_busy},      {31'd0, busy_m});
        chk({tag, ".jt"},     {31'd0, jump_taken},   {31'd0, jt_m});
        chk({tag, ".bt"},     {31'd0, branch_taken}, {31'd0, bt_m});
        chk({tag, ".flush"},  {31'd0, flush_if},     {31'd0, fl_m});
        chk({tag, ".pstall"}, perf_stall_cycles, ps_m);
        chk({tag, ".pflush"}, perf_flushes, pf_m);
        if (e_stall >= 0) chk({tag, ".dir_stall"}, {31'd0, stall}, 32'(e_stall));
        if (e_jt >= 0)    chk({tag, ".dir_jt"}, {31'd0, jump_taken}, 32'(e_jt));
        if (e_bt >= 0)    chk({tag, ".dir_bt"}, {31'd0, branch_taken}, 32'(e_bt));
        if (e_fl >= 0)    chk({tag, ".dir_flush"}, {31'd0, flush_if}, 32'(e_fl));
        if (rst) begin
            busy_left = 0; cnt_stall = 0; cnt_flush = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            else if (md_start) busy_left = LAT - 1;
            cnt_stall += int'(stall_m);
            cnt_flush += int'(fl_m);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        cyc("reset0", 0, 0, 0, 0);
        cyc("reset1", 0, 0, 0, 0);
        idle();
        cyc("idle", 0, 0, 0, 0);

        // load-use on rs, then the same with ex_rt = 0
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        cyc("lu_hit", 1, -1, -1, -1);
        idle();
        cyc("lu_clear", 0, -1, -1, -1);
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        cyc("lu_r0", 0, -1, -1, -1);
        idle(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd9;
        cyc("lu_rt", 1, -1, -1, -1);

        // multiply with a jump held behind it
        idle(); md_start = 1'b1;
        cyc("md_start", 0, 0, 0, 0);
        idle(); jump_req = 1'b1;
        for (int i = 0; i < LAT - 1; i++) cyc("md_busy", 1, 0, 0, 0);
        cyc("md_done", 0, 1, 0, 1);

        // redirect priority
        idle(); jump_req = 1'b1; branch_req = 1'b1;
        cyc("prio", 0, 1, 0, 1);

        // branch under load-use, then released
        idle(); branch_req = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        cyc("br_lu", 1, 0, 0, 0);
        ex_mem_read = 1'b0;
        cyc("br_go", 0, 0, 1, 1);

        // md_start together with load-use
        idle(); md_start = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1;
        cyc("md_lu", 1, -1, -1, -1);
        idle();
        for (int i = 0; i < LAT - 1; i++) cyc("md_lu_busy", 1, -1, -1, -1);
        cyc("md_lu_done", 0, -1, -1, -1);

        // reset on the second busy cycle
        idle(); md_start = 1'b1;
        cyc("rmd_start", 0, -1, -1, -1);
        idle();
        cyc("rmd_busy1", 1, -1, -1, -1);
        rst = 1'b1; jump_req = 1'b1;
        cyc("rmd_rst", 0, 0, 0, 0);
        idle();
        cyc("rmd_after", 0, 0, 0, 0);
        chk("rmd_after_busy_model", 32'(busy_left), 32'd0);

        // three stalls and two flushes from a clean reset
        idle(); rst = 1'b1;
        cyc("perf_rst", 0, -1, -1, -1);
        idle(); ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
        for (int i = 0; i < 3; i++) cyc("perf_lu", 1, -1, -1, -1);
        idle(); branch_req = 1'b1;
        for (int i = 0; i < 2; i++) cyc("perf_br", 0, -1, -1, 1);
        idle();
        #2;
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_stall_total", perf_stall_cycles, 32'd3);
        chk("perf_flush_total", perf_flushes, 32'd2);
`else
        chk("perf_stall_off", perf_stall_cycles, 32'd0);
        chk("perf_flush_off", perf_flushes, 32'd0);
`endif
        @(negedge clk);

        // random traffic; hazards and md_start only issued outside busy windows
        for (int n = 0; n < 400; n++) begin
            idle();
            rst         = ($urandom_range(0, 39) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            id_uses_rs  = 1'($urandom_range(0, 1));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = (busy_left == 0) && ($urandom_range(0, 2) == 0);
            md_start    = (busy_left == 0) && ($urandom_range(0, 5) == 0);
            jump_req    = 1'($urandom_range(0, 1));
            branch_req  = 1'($urandom_range(0, 1));
            cyc("rand", -1, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
